window_apply: RTL

//   Windowing stage downstream of the 8-sample bus packer. On each rising edge of the packer's
//   'set' strobe, captures the 64-bit bus (8 unsigned 8-bit samples, lane 0 = bits [7:0]).

---
 rtl/window_apply.sv | 135 +++++++++++++
 1 files changed

// File: rtl/window_apply.sv
// Window stage: applies a triangular (or loadable) window to 8-lane sample frames via one 8x8 MAC.
// Optional build macro COEF_LOAD_EN adds a runtime-writable coefficient table with coef_* ports.
module window_apply #(
    parameter int unsigned FRAMES = 4,
    localparam int unsigned N = 8 * FRAMES,
    localparam int unsigned ADDR_W = $clog2(8 * FRAMES)
) (
    input  logic              fastclk,
    input  logic              rst_n,
    input  logic [63:0]       in_bus,
    input  logic              set,
    output logic [63:0]       out_bus,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
`ifdef COEF_LOAD_EN
    ,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [7:0]        coef_wdata
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMac  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Triangular window: floor(510*min(k, N-1-k)/(N-1)), built at elaboration.
    function automatic logic [8*N-1:0] coef_table();
        logic [8*N-1:0] t;
        int unsigned    m;
        t = '0;
        for (int unsigned k = 0; k < N; k++) begin
            m = (k < N - 1 - k) ? k : N - 1 - k;
            t[k*8 +: 8] = 8'((510 * m) / (N - 1));
        end
        return t;
    endfunction

    localparam logic [8*N-1:0] COEF_TABLE = coef_table();

    logic [1:0]        state_q, state_d;
    logic              set_d;
    logic              start;
    logic [63:0]       sample_buf;
    logic [2:0]        lane_q;
    logic [2:0]        frame_idx_q;
    logic [55:0]       res_q;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        coef_val;
    logic [7:0]        lane_sample;
    logic [15:0]       prod;
    logic [15:0]       rounded;

    assign start       = set & ~set_d;
    assign idx         = ADDR_W'({frame_idx_q, lane_q});
    assign lane_sample = sample_buf[{lane_q, 3'b000} +: 8];
    assign prod        = {8'd0, lane_sample} * {8'd0, coef_val};
    assign rounded     = prod + 16'd128;

`ifdef COEF_LOAD_EN
    logic [7:0] coef_q [N];

    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++) begin
                coef_q[k] <= COEF_TABLE[k*8 +: 8];
            end
        end else if (coef_we && (32'(coef_addr) < N)) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    assign coef_val = coef_q[idx];
`else
    assign coef_val = COEF_TABLE[{idx, 3'b000} +: 8];
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StMac;
            StMac:   if (lane_q == 3'd7) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            set_d       <= 1'b1;
            sample_buf  <= '0;
            lane_q      <= '0;
            frame_idx_q <= '0;
            res_q       <= '0;
            out_bus     <= '0;
            overrun     <= 1'b0;
        end else begin
            set_d   <= set;
            state_q <= state_d;
            if (start && (state_q != StIdle)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sample_buf <= in_bus;
                        lane_q     <= '0;
                    end
                end
                StMac: begin
                    for (int unsigned l = 0; l < 7; l++) begin
                        if (lane_q == 3'(l)) res_q[l*8 +: 8] <= rounded[15:8];
                    end
                    // Lane 7 goes straight to the output so out_bus is valid in the DONE cycle.
                    if (lane_q == 3'd7) begin
                        out_bus <= {rounded[15:8], res_q};
                    end
                    lane_q <= lane_q + 3'd1;
                end
                StDone: begin
                    frame_idx_q <= (frame_idx_q == 3'(FRAMES - 1)) ? 3'd0 : frame_idx_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign out_last  = out_valid && (frame_idx_q == 3'(FRAMES - 1));

endmodule
